r_fwft_stage: RTL

- Read-side output stage of the asynchronous FIFO. Sits directly downstream of the read pointer handler and FIFO memory, in the read clock domain.
- Consumes the registered `empty` flag and the memory read data. Drives the handler's `r_en`.
- Presents the FIFO contents as a first-word-fall-through valid/ready stream with full throughput, given the memory's 1-cycle read latency.

---
 rtl/fwft_skid_buf.sv | 55 +++++
 rtl/r_fwft_stage.sv | 55 +++++
 2 files changed

// File: rtl/fwft_skid_buf.sv
// Two-entry in-order holding buffer for the FWFT read stage.
// Entry 0 is the head; a pop shifts entry 1 forward and a push lands in the first free slot after that shift.
module fwft_skid_buf #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [data_width-1:0] head,
    output logic [1:0]            count
);

    logic [data_width-1:0] entry0_q, entry0_d;
    logic [data_width-1:0] entry1_q, entry1_d;
    logic [1:0]            count_q, count_d;
    logic [1:0]            base;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        base     = count_q;
        if (pop) begin
            entry0_d = entry1_q;
            entry1_d = '0;
            base     = count_q - 2'd1;
        end
        // Slot selection uses the post-pop fill so an arrival can become the new head.
        if (push) begin
            if (base == 2'd0) begin
                entry0_d = push_data;
            end else begin
                entry1_d = push_data;
            end
        end
        count_d = base + {1'b0, push};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/r_fwft_stage.sv
// Read-side first-word-fall-through stage of the async FIFO.
// Issues reads ahead of demand so a 1-cycle-latency memory sustains one word per cycle.
module r_fwft_stage #(
    parameter int data_width = 8,
    parameter int buf_depth  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occupancy
);

    localparam logic [2:0] depth_lim = 3'(buf_depth);

    logic       inflight_q, inflight_d;
    logic       pop;
    logic [1:0] held;
    logic [2:0] committed;

    assign pop = m_valid & m_ready;

    // Counting this cycle's pop lets a read issue while the buffer is full, which keeps streaming bubble-free.
    assign committed  = {1'b0, held} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_r_en  = !rst && !fifo_empty && (committed < depth_lim);
    assign inflight_d = fifo_r_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fwft_skid_buf #(
        .data_width(data_width)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(fifo_rdata),
        .pop      (pop),
        .head     (m_data),
        .count    (held)
    );

    assign m_valid   = (held != 2'd0);
    assign occupancy = held + {1'b0, inflight_q};

endmodule
